cfg_reg_bank: RTL and testbench
===============================

// Module: cfg_reg_bank
// PURPOSE
//  Parametrised configuration register bank: separate write and read ports, per-bit write mask,
//  per-register reset values and write-protect, and a 1- or 2-stage read pipeline with valid.
//  Exports the low NUM_EXP registers as a flat bus, with change-notify pulses, to the ALU,
//  UART and clock-divider blocks. Sits between the system controller and the datapath.
// PARAMETERS
//  ADDR_W    4                       address width
//  DATA_W    8                       register / data width
//  DEPTH     16                      number of registers, DEPTH <= 2**ADDR_W
//  NUM_EXP   4                       registers 0..NUM_EXP-1 exported, NUM_EXP <= DEPTH
//  RST_VALS  {96'h0,8'h20,8'h81,16'h0}  DEPTH*DATA_W reset image, reg i at bits [i*DATA_W +: DATA_W]
//  RO_MASK   16'h0000                DEPTH bits; bit i = 1 makes reg i read-only
//  RD_LAT    1                       read latency in cycles, 1 or 2
//  WR_BYPASS 1                       1: same-cycle same-address read returns the new value
// PORTS
//  CLK          in   1                clock, rising edge
//  RST          in   1                asynchronous, active-low reset
//  WrEn         in   1                write request, one write per cycle
//  WrAddr       in   ADDR_W           write address
//  WrData       in   DATA_W           write data
//  WrMask       in   DATA_W           bit i = 1 writes bit i; other bits keep their value
//  RdEn         in   1                read request, one read per cycle
//  RdAddr       in   ADDR_W           read address
//  RdData       out  DATA_W           read data
//  RdData_Valid out  1                one-cycle pulse for each read result
//  Err          out  1                one-cycle pulse on an illegal access
//  Exp_Regs     out  NUM_EXP*DATA_W   live contents of regs 0..NUM_EXP-1, reg 0 in the LSBs
//  Exp_Upd      out  NUM_EXP          bit i pulses when exported reg i changes value
// BEHAVIOUR
//  Reset (RST low, async):
//   - every reg i loads RST_VALS slice i
//   - RdData=0, RdData_Valid=0, Err=0, Exp_Upd=0; read pipeline flushed
//   - a read in flight when reset asserts is dropped and never produces a valid
//  Write (WrEn=1 at edge): legal when WrAddr<DEPTH and RO_MASK[WrAddr]=0
//   - legal: reg <= (reg & ~WrMask) | (WrData & WrMask); result visible on the next cycle
//   - illegal: no register changes; Err=1 on the next cycle
//  Exp_Upd[i]=1 for one cycle, on the cycle after the edge, when a write changes reg i
//   (i<NUM_EXP); a masked or same-value write gives no pulse
//  Read (RdEn=1 at edge N):
//   - RdData and RdData_Valid=1 appear after edge N+RD_LAT-1 (RD_LAT=1: visible cycle N+1)
//   - fully pipelined: back-to-back reads give back-to-back valids, in order
//   - RdAddr>=DEPTH: RdData=0, RdData_Valid=1, and Err pulses with the valid
//   - read-only registers read normally
//  RdData holds its last value when RdData_Valid=0
//  Same cycle, same address, legal write:
//   - WR_BYPASS=1: read returns the merged new value
//   - WR_BYPASS=0: read returns the old value
//   - different addresses: write and read are independent
//  Err: a write error and a read error landing in the same cycle give a single Err pulse
//  Bus widths: address compare is unsigned; Exp_Regs is combinational from the registers
// TESTING
//  T1 reset: pulse RST low mid-read -> reg2=0x81, reg3=0x20, others 0; no RdData_Valid after release
//  T2 masked write: reg5=0x00, write 0xFF with WrMask=0x0F; read 5 -> RdData=0x0F, valid 1 cycle later (RD_LAT=1)
//  T3 RO_MASK[3]=1: write 0x55 to reg3 -> reg3 stays 0x20, Err pulses once, Exp_Upd=0
//  T4 collision: reg1=0x10; write 0x22 to reg1 and read reg1 same cycle -> 0x22 (WR_BYPASS=1) / 0x10 (WR_BYPASS=0)
//  T5 RD_LAT=2: reads of addr 0,1,2 on consecutive cycles -> 3 consecutive valids, in order, 2 cycles after each request
//  T6 DEPTH=12, read addr 14 -> RdData=0, Valid=1, Err=1 in the same cycle; write 0x20 to reg3 -> no Exp_Upd[3]

Source files
------------

// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: parametrised configuration register bank with masked writes,
// per-register reset values and write-protect, a 1- or 2-stage read pipeline,
// and the low NUM_EXP registers exported with change-notify pulses.
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   WrEn/WrAddr/WrData/WrMask   write port; WrMask bit 1 writes that data bit
//   RdEn/RdAddr     read request port
//   RdData/RdData_Valid         read result and its one-cycle valid pulse
//   Err             one-cycle pulse on an illegal write or out-of-range read
//   Exp_Regs        live contents of regs 0..NUM_EXP-1, reg 0 in the LSBs
//   Exp_Upd         bit i pulses the cycle after a write changes exported reg i
module cfg_reg_bank #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH = 16,
    parameter int NUM_EXP = 4,
    parameter logic [DEPTH*DATA_W-1:0] RST_VALS = {96'h0, 8'h20, 8'h81, 16'h0},
    parameter logic [DEPTH-1:0] RO_MASK = 16'h0000,
    parameter int RD_LAT = 1,
    parameter int WR_BYPASS = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      WrEn,
    input  logic [ADDR_W-1:0]         WrAddr,
    input  logic [DATA_W-1:0]         WrData,
    input  logic [DATA_W-1:0]         WrMask,
    input  logic                      RdEn,
    input  logic [ADDR_W-1:0]         RdAddr,
    output logic [DATA_W-1:0]         RdData,
    output logic                      RdData_Valid,
    output logic                      Err,
    output logic [NUM_EXP*DATA_W-1:0] Exp_Regs,
    output logic [NUM_EXP-1:0]        Exp_Upd
);
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]  regs [DEPTH];
    logic               wr_in, wr_ok, wr_err, rd_in, rd_err;
    logic [DATA_W-1:0]  merged, rd_val;
    logic [NUM_EXP-1:0] upd;
    logic               p_v, p_e;
    logic [DATA_W-1:0]  p_d;

    // The RO_MASK lookup is only meaningful in range, so it is gated by wr_in.
    always_comb begin
        wr_in  = {1'b0, WrAddr} < LIMIT;
        wr_ok  = WrEn && wr_in && !RO_MASK[WrAddr];
        wr_err = WrEn && !wr_ok;
        merged = (regs[WrAddr] & ~WrMask) | (WrData & WrMask);
        rd_in  = {1'b0, RdAddr} < LIMIT;
        rd_err = RdEn && !rd_in;
        rd_val = !rd_in ? '0 :
                 (WR_BYPASS != 0 && wr_ok && WrAddr == RdAddr) ? merged : regs[RdAddr];
    end

    // A notify fires only when the stored value actually changes.
    always_comb begin
        upd = '0;
        for (int i = 0; i < NUM_EXP; i++)
            upd[i] = wr_ok && WrAddr == ADDR_W'(i) && merged != regs[i];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= RST_VALS[i*DATA_W +: DATA_W];
        end else if (wr_ok) begin
            regs[WrAddr] <= merged;
        end
    end

    // Stage p holds the read result one extra cycle when RD_LAT is 2; a
    // read-range error travels with its data so Err lines up with the valid.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_v          <= 1'b0;
            p_e          <= 1'b0;
            p_d          <= '0;
            RdData       <= '0;
            RdData_Valid <= 1'b0;
            Err          <= 1'b0;
            Exp_Upd      <= '0;
        end else begin
            p_v     <= RdEn;
            p_e     <= rd_err;
            p_d     <= RdEn ? rd_val : p_d;
            Exp_Upd <= upd;
            if (RD_LAT == 2) begin
                RdData_Valid <= p_v;
                RdData       <= p_v ? p_d : RdData;
                Err          <= wr_err | p_e;
            end else begin
                RdData_Valid <= RdEn;
                RdData       <= RdEn ? rd_val : RdData;
                Err          <= wr_err | rd_err;
            end
        end
    end

    for (genvar i = 0; i < NUM_EXP; i++) begin : g_exp
        assign Exp_Regs[i*DATA_W +: DATA_W] = regs[i];
    end
endmodule

// File: tb/tb_cfg_reg_bank.sv
// tb_cfg_reg_bank: directed bench for cfg_reg_bank. Two instances share the
// input stimulus: a = 16 regs, reg 3 read-only, RD_LAT 1, bypass on;
// b = 12 regs, no protection, RD_LAT 2, bypass off.
module tb_cfg_reg_bank;
    logic       CLK = 1'b0, RST = 1'b0;
    logic       WrEn = 1'b0, RdEn = 1'b0;
    logic [3:0] WrAddr = '0, RdAddr = '0;
    logic [7:0] WrData = '0, WrMask = '0;
    logic [7:0]  a_rd, b_rd;
    logic        a_vld, b_vld, a_err, b_err;
    logic [31:0] a_exp, b_exp;
    logic [3:0]  a_upd, b_upd;
    int n_chk = 0, n_pass = 0;

    always #5 CLK = ~CLK;

    cfg_reg_bank #(.RO_MASK(16'h0008), .RD_LAT(1), .WR_BYPASS(1)) dut_a (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .WrMask(WrMask), .RdEn(RdEn), .RdAddr(RdAddr), .RdData(a_rd),
        .RdData_Valid(a_vld), .Err(a_err), .Exp_Regs(a_exp), .Exp_Upd(a_upd));

    cfg_reg_bank #(.DEPTH(12), .RST_VALS({64'h0, 8'h20, 8'h81, 16'h0}),
                   .RO_MASK(12'h000), .RD_LAT(2), .WR_BYPASS(0)) dut_b (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .WrMask(WrMask), .RdEn(RdEn), .RdAddr(RdAddr), .RdData(b_rd),
        .RdData_Valid(b_vld), .Err(b_err), .Exp_Regs(b_exp), .Exp_Upd(b_upd));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                         input logic [7:0] wm, input logic re, input logic [3:0] ra);
        WrEn = we; WrAddr = wa; WrData = wd; WrMask = wm; RdEn = re; RdAddr = ra;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("rst_a_vld", a_vld, 0);
        check("rst_a_exp", a_exp, 32'h2081_0000);
        check("rst_b_exp", b_exp, 32'h2081_0000);
        check("rst_b_rd", b_rd, 0);
        check("rst_a_err", a_err, 0);
        check("rst_a_upd", a_upd, 0);
        RST = 1'b1;
        // T1: reset pulse while a read is in flight
        drive(0, 0, 0, 0, 1, 2);
        @(posedge CLK);
        #2 RST = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        check("t1_a_flush", a_vld, 0);
        check("t1_a_rd", a_rd, 0);
        RST = 1'b1;
        cyc();
        check("t1_b_drop", b_vld, 0);
        cyc();
        check("t1_b_drop2", b_vld, 0);
        drive(0, 0, 0, 0, 1, 3);
        cyc();
        check("t1_a_reg3", a_rd, 8'h20);
        check("t1_a_vld", a_vld, 1);
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        check("t1_b_reg3", b_rd, 8'h20);
        check("t1_b_vld", b_vld, 1);
        cyc();
        check("t1_b_vld_end", b_vld, 0);
        // T2: masked write to reg 5
        drive(1, 5, 8'hFF, 8'h0F, 0, 0);
        cyc();
        check("t2_a_upd", a_upd, 0);
        drive(0, 0, 0, 0, 1, 5);
        cyc();
        check("t2_a_rd", a_rd, 8'h0F);
        check("t2_a_vld", a_vld, 1);
        check("t2_b_vld_early", b_vld, 0);
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        check("t2_a_vld_drop", a_vld, 0);
        check("t2_a_hold", a_rd, 8'h0F);
        check("t2_b_rd", b_rd, 8'h0F);
        check("t2_b_vld", b_vld, 1);
        cyc();
        // T3: write to read-only reg 3 on a; writable on b
        drive(1, 3, 8'h55, 8'hFF, 0, 0);
        cyc();
        check("t3_a_err", a_err, 1);
        check("t3_a_upd", a_upd, 0);
        check("t3_a_reg3", a_exp[31:24], 8'h20);
        check("t3_b_err", b_err, 0);
        check("t3_b_upd", b_upd, 4'b1000);
        check("t3_b_reg3", b_exp[31:24], 8'h55);
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        check("t3_a_err_once", a_err, 0);
        // T4: same-cycle write and read of reg 1
        drive(1, 1, 8'h10, 8'hFF, 0, 0);
        cyc();
        check("t4_a_upd_set", a_upd, 4'b0010);
        drive(1, 1, 8'h22, 8'hFF, 1, 1);
        cyc();
        check("t4_a_bypass", a_rd, 8'h22);
        check("t4_a_vld", a_vld, 1);
        check("t4_a_upd", a_upd, 4'b0010);
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        check("t4_b_old", b_rd, 8'h10);
        check("t4_b_vld", b_vld, 1);
        // T5: back-to-back reads on the 2-stage pipeline (regs 0,1,2 = 00,22,81)
        drive(0, 0, 0, 0, 1, 0);
        cyc();
        check("t5_b_lat", b_vld, 0);
        drive(0, 0, 0, 0, 1, 1);
        cyc();
        check("t5_b_v0", b_vld, 1);
        check("t5_b_d0", b_rd, 8'h00);
        drive(0, 0, 0, 0, 1, 2);
        cyc();
        check("t5_b_v1", b_vld, 1);
        check("t5_b_d1", b_rd, 8'h22);
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        check("t5_b_v2", b_vld, 1);
        check("t5_b_d2", b_rd, 8'h81);
        cyc();
        check("t5_b_v_end", b_vld, 0);
        check("t5_b_hold", b_rd, 8'h81);
        // T6: out-of-range read on b, same-value and masked writes
        drive(0, 0, 0, 0, 1, 14);
        cyc();
        check("t6_b_err_early", b_err, 0);
        check("t6_a_rd14", a_rd, 8'h00);
        check("t6_a_err", a_err, 0);
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        check("t6_b_rd", b_rd, 8'h00);
        check("t6_b_vld", b_vld, 1);
        check("t6_b_err", b_err, 1);
        cyc();
        check("t6_b_err_once", b_err, 0);
        drive(1, 3, 8'h20, 8'hFF, 0, 0);
        cyc();
        check("t6_b_upd_chg", b_upd, 4'b1000);
        cyc();
        check("t6_b_upd_same", b_upd, 4'b0000);
        check("t6_b_reg3", b_exp[31:24], 8'h20);
        drive(1, 0, 8'hFF, 8'h00, 0, 0);
        cyc();
        check("t6_b_upd_mask", b_upd, 0);
        check("t6_a_upd_mask", a_upd, 0);
        check("t6_b_reg0", b_exp[7:0], 8'h00);
        drive(1, 13, 8'hAA, 8'hFF, 0, 0);
        cyc();
        check("t6_b_wr_err", b_err, 1);
        check("t6_a_wr13", a_err, 0);
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
